// File: rtl/systolic_array_ws.sv
// Weight-stationary ROWS x COLS systolic array computing y[c] = sum_r x[r]*W[r][c] with ROWS+COLS latency.
// Optional macro SYSTOLIC_RELU_EN clamps negative results to zero in the output register.
module systolic_array_ws #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_start,
    input  logic                       w_valid,
    input  logic [COLS*DATA_WIDTH-1:0] w_data,
    input  logic                       in_valid,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    output logic                       in_ready,
    output logic                       weights_ready,
    output logic                       out_valid,
    output logic [COLS*ACC_WIDTH-1:0]  out_data
);
    localparam int DW  = DATA_WIDTH;
    localparam int AW  = ACC_WIDTH;
    localparam int LAT = ROWS + COLS;
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int IW  = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, READY, DRAIN} state_t;

    state_t              state_reg, state_next;
    logic [RW-1:0]       row_cnt_reg;
    logic [IW-1:0]       inflight_reg;
    logic                weights_ready_reg;
    logic [LAT-1:0]      valid_pipe_reg;
    logic                out_valid_reg;
    logic [COLS*AW-1:0]  out_data_reg;
    logic                load_enter, row_wr, load_done, accept;

    logic signed [DW-1:0] w_reg   [ROWS][COLS];
    logic signed [DW-1:0] a_in    [ROWS][COLS];
    logic signed [AW-1:0] psum_in [ROWS+1][COLS];
    logic signed [AW-1:0] col_out [COLS];

    genvar gi, gj;

    assign in_ready      = (state_reg == READY) && !load_start;
    assign accept        = in_valid && in_ready;
    assign weights_ready = weights_ready_reg;
    assign out_valid     = out_valid_reg;
    assign out_data      = out_data_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load_enter = 1'b0;
        row_wr     = 1'b0;
        load_done  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load_start) begin
                    state_next = LOAD;
                    load_enter = 1'b1;
                end
            end
            LOAD: begin
                // A fresh load_start restarts the row sequence; its beat is discarded.
                if (load_start) begin
                    load_enter = 1'b1;
                end else if (w_valid) begin
                    row_wr = 1'b1;
                    if (row_cnt_reg == RW'(ROWS - 1)) begin
                        load_done  = 1'b1;
                        state_next = READY;
                    end
                end
            end
            READY: begin
                if (load_start) begin
                    if (inflight_reg == '0) begin
                        state_next = LOAD;
                        load_enter = 1'b1;
                    end else begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (inflight_reg == '0) begin
                    state_next = LOAD;
                    load_enter = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_cnt_reg       <= '0;
            weights_ready_reg <= 1'b0;
        end else if (load_enter) begin
            row_cnt_reg       <= '0;
            weights_ready_reg <= 1'b0;
        end else if (row_wr) begin
            row_cnt_reg <= load_done ? '0 : row_cnt_reg + 1'b1;
            if (load_done) weights_ready_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    w_reg[r][c] <= '0;
        end else if (row_wr) begin
            for (int c = 0; c < COLS; c++)
                w_reg[row_cnt_reg][c] <= w_data[c*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_reg <= '0;
        end else begin
            case ({accept, out_valid_reg})
                2'b10:   inflight_reg <= inflight_reg + 1'b1;
                2'b01:   inflight_reg <= inflight_reg - 1'b1;
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) valid_pipe_reg <= '0;
        else        valid_pipe_reg <= {valid_pipe_reg[LAT-2:0], accept};
    end

    // Capture register plus gi skew stages; bubbles enter as zero.
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_skew
            logic signed [DW-1:0] skew_reg [gi+1];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k <= gi; k++) skew_reg[k] <= '0;
                end else begin
                    skew_reg[0] <= accept ? in_data[gi*DW +: DW] : '0;
                    for (int k = 1; k <= gi; k++) skew_reg[k] <= skew_reg[k-1];
                end
            end
            assign a_in[gi][0] = skew_reg[gi];
        end

        for (gj = 0; gj < COLS; gj++) begin : g_top
            assign psum_in[0][gj] = '0;
        end

        for (gi = 0; gi < ROWS; gi++) begin : g_row
            for (gj = 0; gj < COLS; gj++) begin : g_col
                logic signed [2*DW-1:0] prod;
                logic signed [AW-1:0]   psum_reg;
                assign prod = (2*DW)'(a_in[gi][gj]) * (2*DW)'(w_reg[gi][gj]);
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) psum_reg <= '0;
                    else        psum_reg <= psum_in[gi][gj] + AW'(prod);
                end
                assign psum_in[gi+1][gj] = psum_reg;

                if (gj < COLS - 1) begin : g_fwd
                    logic signed [DW-1:0] a_reg;
                    always_ff @(posedge clk or negedge reset) begin
                        if (!reset) a_reg <= '0;
                        else        a_reg <= a_in[gi][gj];
                    end
                    assign a_in[gi][gj+1] = a_reg;
                end
            end
        end

        // Column gj leaves the array COLS-1-gj cycles early; delay it to line up.
        for (gj = 0; gj < COLS; gj++) begin : g_deskew
            if (gj == COLS - 1) begin : g_pass
                assign col_out[gj] = psum_in[ROWS][gj];
            end else begin : g_dly
                logic signed [AW-1:0] ds_reg [COLS-1-gj];
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        for (int k = 0; k < COLS - 1 - gj; k++) ds_reg[k] <= '0;
                    end else begin
                        ds_reg[0] <= psum_in[ROWS][gj];
                        for (int k = 1; k < COLS - 1 - gj; k++) ds_reg[k] <= ds_reg[k-1];
                    end
                end
                assign col_out[gj] = ds_reg[COLS-2-gj];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= valid_pipe_reg[LAT-1];
            if (valid_pipe_reg[LAT-1]) begin
                for (int c = 0; c < COLS; c++) begin
`ifdef SYSTOLIC_RELU_EN
                    out_data_reg[c*AW +: AW] <= col_out[c][AW-1] ? '0 : col_out[c];
`else
                    out_data_reg[c*AW +: AW] <= col_out[c];
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_array_ws.sv
// Directed self-checking bench for systolic_array_ws (4x4, 16-bit data, 40-bit sums).
module tb_systolic_array_ws;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 16;
    localparam int AW   = 40;
    localparam int LAT  = ROWS + COLS;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 load_start = 1'b0;
    logic                 w_valid = 1'b0;
    logic [COLS*DW-1:0]   w_data = '0;
    logic                 in_valid = 1'b0;
    logic [ROWS*DW-1:0]   in_data = '0;
    logic                 in_ready, weights_ready, out_valid;
    logic [COLS*AW-1:0]   out_data;

    int checks = 0;
    int failures = 0;

    logic               s_iv  [16];
    logic               s_ls  [16];
    logic               s_rdy [16];
    logic [ROWS*DW-1:0] s_x   [16];
    logic [COLS*AW-1:0] s_y   [16];
    logic [COLS*AW-1:0] hold_y = '0;
    logic [ROWS*COLS*DW-1:0] wm;

    always #5 clk = ~clk;

    systolic_array_ws #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .w_valid(w_valid), .w_data(w_data),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .weights_ready(weights_ready), .out_valid(out_valid), .out_data(out_data)
    );

    task automatic check(input string tag, input logic [COLS*AW-1:0] got, input logic [COLS*AW-1:0] expected);
        checks++;
        if (got !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, expected);
        end
    endtask

    function automatic logic [ROWS*DW-1:0] pack_x(input int x0, input int x1, input int x2, input int x3);
        int v [4];
        logic [ROWS*DW-1:0] p;
        v[0] = x0; v[1] = x1; v[2] = x2; v[3] = x3;
        for (int r = 0; r < ROWS; r++) p[r*DW +: DW] = v[r][DW-1:0];
        return p;
    endfunction

    function automatic logic [COLS*AW-1:0] pack_y(input int y0, input int y1, input int y2, input int y3);
        int v [4];
        logic signed [AW-1:0] t;
        logic [COLS*AW-1:0] p;
        v[0] = y0; v[1] = y1; v[2] = y2; v[3] = y3;
        for (int c = 0; c < COLS; c++) begin
            t = AW'(v[c]);
`ifdef SYSTOLIC_RELU_EN
            if (t < 0) t = '0;
`endif
            p[c*AW +: AW] = t;
        end
        return p;
    endfunction

    task automatic set_slot(input int i, input logic iv, input logic ls, input logic rdy,
                            input logic [ROWS*DW-1:0] x, input logic [COLS*AW-1:0] y);
        s_iv[i] = iv; s_ls[i] = ls; s_rdy[i] = rdy; s_x[i] = x; s_y[i] = y;
    endtask

    // Drive n slots, then keep watching until every result (plus one cycle) has emerged.
    task automatic run_stream(input int n, input string name);
        logic exp_v;
        for (int i = 0; i <= n + LAT; i++) begin
            if (i < n) begin
                in_valid = s_iv[i]; load_start = s_ls[i]; in_data = s_x[i];
            end else begin
                in_valid = 1'b0; load_start = 1'b0; in_data = '0;
            end
            #1;
            if (i < n) check($sformatf("%s_in_ready_%0d", name, i), in_ready, s_rdy[i]);
            @(posedge clk); #1;
            exp_v = 1'b0;
            if (i >= LAT && i - LAT < n) exp_v = s_iv[i-LAT] && s_rdy[i-LAT];
            check($sformatf("%s_out_valid_%0d", name, i), out_valid, exp_v);
            if (exp_v) hold_y = s_y[i-LAT];
            check($sformatf("%s_out_data_%0d", name, i), out_data, hold_y);
            if (exp_v) $display("tx %s slot %0d out_data=%h", name, i - LAT, out_data);
        end
        in_valid = 1'b0; load_start = 1'b0;
    endtask

    task automatic load_w(input logic [ROWS*COLS*DW-1:0] m, input logic do_start,
                          input logic junk_iv, input string name);
        if (do_start) begin
            load_start = 1'b1;
            @(posedge clk); #1;
            load_start = 1'b0;
        end
        in_valid = junk_iv;
        in_data  = pack_x(9, 9, 9, 9);
        for (int r = 0; r < ROWS; r++) begin
            w_valid = 1'b1;
            w_data  = m[r*COLS*DW +: COLS*DW];
            #1;
            check($sformatf("%s_load_in_ready_%0d", name, r), in_ready, 1'b0);
            @(posedge clk); #1;
            check($sformatf("%s_wready_beat_%0d", name, r), weights_ready, r == ROWS - 1);
            $display("tx %s weight row %0d w_data=%h", name, r, w_data);
        end
        w_valid = 1'b0; w_data = '0; in_valid = 1'b0; in_data = '0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_weights_ready", weights_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", in_ready, 1'b0);

        // Identity weights, single vector, exact latency
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                wm[(r*COLS+c)*DW +: DW] = (r == c) ? 16'd1 : 16'd0;
        load_w(wm, 1'b1, 1'b0, "ident");
        set_slot(0, 1, 0, 1, pack_x(1, 2, 3, 4), pack_y(1, 2, 3, 4));
        run_stream(1, "ident");

        // All -1 weights; back-to-back with a bubble
        wm = '1;
        load_w(wm, 1'b1, 1'b0, "neg");
        set_slot(0, 1, 0, 1, pack_x(100, -200, 300, -400), pack_y(200, 200, 200, 200));
        set_slot(1, 1, 0, 1, pack_x(1, 1, 1, 1),           pack_y(-4, -4, -4, -4));
        set_slot(2, 1, 0, 1, pack_x(-5, 0, 0, 0),          pack_y(5, 5, 5, 5));
        set_slot(3, 0, 0, 1, pack_x(0, 0, 0, 0),           pack_y(0, 0, 0, 0));
        set_slot(4, 1, 0, 1, pack_x(7, 7, 7, 7),           pack_y(-28, -28, -28, -28));
        run_stream(5, "bubble");

        // Stray w_valid in READY must not disturb the weights
        w_valid = 1'b1;
        w_data  = {COLS{16'h1234}};
        repeat (3) @(posedge clk);
        #1;
        w_valid = 1'b0; w_data = '0;
        check("stray_wready", weights_ready, 1'b1);
        set_slot(0, 1, 0, 1, pack_x(100, -200, 300, -400), pack_y(200, 200, 200, 200));
        set_slot(1, 1, 0, 1, pack_x(0, 0, 0, -9),          pack_y(9, 9, 9, 9));
        run_stream(2, "stray");

        // load_start with two vectors in flight: drain on old weights, then reload
        set_slot(0, 1, 0, 1, pack_x(-1, -2, -3, -4), pack_y(10, 10, 10, 10));
        set_slot(1, 1, 0, 1, pack_x(0, 0, -6, 0),    pack_y(6, 6, 6, 6));
        set_slot(2, 1, 1, 0, pack_x(50, 50, 50, 50), pack_y(0, 0, 0, 0));
        set_slot(3, 1, 0, 0, pack_x(50, 50, 50, 50), pack_y(0, 0, 0, 0));
        run_stream(4, "drain");
        @(posedge clk); #1;
        check("drain_wready_in_load", weights_ready, 1'b0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                wm[(r*COLS+c)*DW +: DW] = 16'(r*COLS + c + 1);
        load_w(wm, 1'b0, 1'b1, "w3");
        set_slot(0, 1, 0, 1, pack_x(0, 0, 0, -1), pack_y(-13, -14, -15, -16));
        set_slot(1, 1, 0, 1, pack_x(1, 2, 3, 4),  pack_y(90, 100, 110, 120));
        set_slot(2, 1, 0, 1, pack_x(1, 0, 0, 0),  pack_y(1, 2, 3, 4));
        run_stream(3, "w3");

        // Reset mid-stream aborts the in-flight vector
        in_valid = 1'b1;
        in_data  = pack_x(1, 1, 1, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_weights_ready", weights_ready, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, '0);
        #3 reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check($sformatf("midrst_no_out_%0d", i), out_valid, 1'b0);
        end
        check("midrst_out_data_end", out_data, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/systolic_array_ws.md
Name: systolic_array_ws

Overview:
- Parametrised ROWS x COLS weight-stationary systolic array for signed vector-matrix multiply: y[c] = sum over r of x[r]*W[r][c].
- Successor to the fixed 2x2 array with external write-enables and mux selects.
- Adds an internal weight-load FSM, input skew and output deskew registers, a valid/ready input handshake and a fixed-latency output.
- Sits between the operand buffers and the accumulator/writeback stage of the MMM datapath.

Parameters:
- ROWS, 4, PE rows; input vector length; number of weight rows.
- COLS, 4, PE columns; output vector length.
- DATA_WIDTH, 16, signed width of weights and activations.
- ACC_WIDTH, 40, signed width of partial sums and outputs; must be >= 2*DATA_WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_start  input  1  request a new weight load.
- w_valid  input  1  one weight-row beat is present on w_data.
- w_data  input  COLS*DATA_WIDTH  weight row; element c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  1  activation vector is present on in_data.
- in_data  input  ROWS*DATA_WIDTH  activation vector; element r at [r*DATA_WIDTH +: DATA_WIDTH].
- in_ready  output  1  array accepts an activation vector this cycle.
- weights_ready  output  1  a complete weight set is loaded.
- out_valid  output  1  out_data holds a result this cycle (single-cycle pulse per result).
- out_data  output  COLS*ACC_WIDTH  result vector; element c at [c*ACC_WIDTH +: ACC_WIDTH].

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - All weights, pipeline data and valid bits = 0; row counter and in-flight counter = 0.
  - Outputs: in_ready=0, weights_ready=0, out_valid=0, out_data=0.
- FSM states: IDLE, LOAD, READY, DRAIN.
  - IDLE: load_start -> LOAD.
  - READY: load_start with in-flight=0 -> LOAD; with in-flight>0 -> DRAIN.
  - DRAIN: stays until in-flight=0, then -> LOAD. load_start is ignored in DRAIN.
  - LOAD: each w_valid writes w_data into weight row row_cnt, then row_cnt++. The beat with row_cnt=ROWS-1 -> READY and weights_ready=1. load_start in LOAD resets row_cnt to 0 and stays in LOAD.
  - w_valid outside LOAD is ignored.
- weights_ready:
  - Cleared on entry to LOAD.
  - A partial load leaves it 0; rows not yet written keep their previous values.
- Handshake:
  - in_ready = 1 iff state==READY and load_start==0 (combinational).
  - Transfer occurs when in_valid && in_ready.
  - in_valid while in_ready=0 is dropped, with no side effects.
- Throughput: one vector per cycle, sustained. Bubbles propagate as invalid slots and produce no out_valid.
- Datapath:
  - Activations flow left to right; partial sums flow top to bottom.
  - Input row r is skewed by r registers.
  - Output column c is deskewed by COLS-1-c registers.
  - A valid bit travels with each vector.
- Latency: out_valid rises exactly ROWS+COLS cycles after the accepting edge. Results emerge strictly in acceptance order.
- Arithmetic:
  - Signed two's-complement DATA_WIDTH x DATA_WIDTH product, sign-extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH.
- In-flight counter:
  - +1 on accept, -1 on out_valid; both in the same cycle leaves it unchanged.
  - Width clog2(ROWS+COLS+1).
- Weight stability: weights change only in LOAD. Vectors in flight always complete with the weights in place when they were accepted (guaranteed by DRAIN).
- out_data holds its last value when out_valid=0.
- Reset mid-operation (any state) aborts all in-flight vectors; no out_valid is produced for them.

Optional Feature:
- Macro: SYSTOLIC_RELU_EN.
- Defined: each out_data element is max(y[c], 0), applied in the final output register stage. Latency is unchanged.
- Undefined: raw signed sums are output.

Test Plan:
- Reset asserted mid-stream with defaults -> in_ready=0, weights_ready=0, out_valid=0, out_data=0 immediately; the in-flight vector never appears.
- Load identity W (4 beats); accept x={1,2,3,4} at edge T -> out_valid only at edge T+8, out_data={1,2,3,4}.
- W all 0xFFFF (-1); x={100,-200,300,-400} -> every column = 200. Without SYSTOLIC_RELU_EN, x={1,1,1,1} -> each column = -4 (0xFFFFFFFFFC); with SYSTOLIC_RELU_EN -> 0.
- Three vectors back-to-back, one bubble, then a fourth -> out_valid pattern 1,1,1,0,1 starting at T+8, with correct values in order.
- load_start with 2 vectors in flight -> in_ready drops the same cycle; state DRAIN; both results use the old weights; then LOAD, and weights_ready=0 until 4 w_valid beats.
- w_valid in READY, and in_valid during LOAD -> both ignored; weights and output stream unchanged.
